// File: rtl/ray_calc_arbiter.sv
// Round-robin arbiter that time-shares one fixed-latency radius datapath between N_CH channels
// and returns each datapath result tagged with the channel that issued it.

module ray_calc_arbiter #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CH_W         = 2,
    parameter int unsigned IN_W         = 8,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned CALC_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      req_valid,
    output logic [N_CH-1:0]      req_ready,
    input  logic [N_CH*IN_W-1:0] req_x,
    input  logic [N_CH*IN_W-1:0] req_y,
    output logic [IN_W-1:0]      calc_x,
    output logic [IN_W-1:0]      calc_y,
    input  logic [OUT_W-1:0]     calc_r,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_ch,
    output logic [OUT_W-1:0]     res_r,
    output logic                 busy
);

    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic                found_hi, found_lo, grant_any, xfer;
    logic [CH_W-1:0]     grant_hi, grant_lo, grant_idx;
    logic [IN_W-1:0]     sel_x, sel_y;

    logic [IN_W-1:0]     calc_x_q, calc_x_d;
    logic [IN_W-1:0]     calc_y_q, calc_y_d;

    // Index 0 is the issue register; index CALC_LATENCY lines up with calc_r.
    logic [CALC_LATENCY:0] tag_vld_q, tag_vld_d;
    logic [CH_W-1:0]       tag_ch_q [CALC_LATENCY+1];
    logic [CH_W-1:0]       tag_ch_d [CALC_LATENCY+1];

    logic                res_valid_q, res_valid_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [OUT_W-1:0]    res_r_q, res_r_d;

    // Rotating priority: the first requester at or above the pointer wins, otherwise the
    // lowest requester overall (which then necessarily sits below the pointer).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        grant_hi = '0;
        grant_lo = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (!found_hi && req_valid[c] && (c >= 32'(ptr_q))) begin
                found_hi = 1'b1;
                grant_hi = CH_W'(c);
            end
            if (!found_lo && req_valid[c]) begin
                found_lo = 1'b1;
                grant_lo = CH_W'(c);
            end
        end
        grant_any = found_hi | found_lo;
        grant_idx = found_hi ? grant_hi : grant_lo;
        xfer      = grant_any & ~reset;
    end

    always_comb begin
        req_ready = '0;
        sel_x     = '0;
        sel_y     = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                req_ready[c] = xfer;
                sel_x        = req_x[c*IN_W +: IN_W];
                sel_y        = req_y[c*IN_W +: IN_W];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        calc_x_d    = calc_x_q;
        calc_y_d    = calc_y_q;
        tag_vld_d   = {tag_vld_q[CALC_LATENCY-1:0], xfer};
        tag_ch_d[0] = grant_idx;
        for (int unsigned k = 1; k <= CALC_LATENCY; k++) begin
            tag_ch_d[k] = tag_ch_q[k-1];
        end
        res_valid_d = tag_vld_q[CALC_LATENCY];
        res_ch_d    = res_ch_q;
        res_r_d     = res_r_q;

        if (xfer) begin
            calc_x_d = sel_x;
            calc_y_d = sel_y;
            ptr_d    = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (tag_vld_q[CALC_LATENCY]) begin
            res_ch_d = tag_ch_q[CALC_LATENCY];
            res_r_d  = calc_r;
        end
    end

    always_ff @(posedge clk) begin
        tag_ch_q <= tag_ch_d;
        if (reset) begin
            ptr_q       <= '0;
            calc_x_q    <= '0;
            calc_y_q    <= '0;
            tag_vld_q   <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_r_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            calc_x_q    <= calc_x_d;
            calc_y_q    <= calc_y_d;
            tag_vld_q   <= tag_vld_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_r_q     <= res_r_d;
        end
    end

    assign calc_x    = calc_x_q;
    assign calc_y    = calc_y_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_r     = res_r_q;
    assign busy      = |tag_vld_q;

endmodule

// File: tb/tb_ray_calc_arbiter.sv
// Bench for ray_calc_arbiter: behavioural datapath beside the DUT, a queue-based reference
// model checked every cycle, and directed scenarios with hand-computed expectations.

module tb_ray_calc_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int IW = 8;
    localparam int OW = 8;
    localparam int L  = 3;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*IW-1:0] req_x;
    logic [N*IW-1:0] req_y;
    logic [IW-1:0]   calc_x;
    logic [IW-1:0]   calc_y;
    logic [OW-1:0]   calc_r;
    logic            res_valid;
    logic [CW-1:0]   res_ch;
    logic [OW-1:0]   res_r;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    ray_calc_arbiter #(
        .N_CH        (N),
        .CH_W        (CW),
        .IN_W        (IW),
        .OUT_W       (OW),
        .CALC_LATENCY(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_x    (req_x),
        .req_y    (req_y),
        .calc_x   (calc_x),
        .calc_y   (calc_y),
        .calc_r   (calc_r),
        .res_valid(res_valid),
        .res_ch   (res_ch),
        .res_r    (res_r),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int isqrt(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic int radius(input logic [7:0] x, input logic [7:0] y);
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        return isqrt(sx * sx + sy * sy);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Shared datapath: calc_r in cycle t is the radius of the operands presented in cycle t-L.
    int dp [L+1];
    initial begin
        calc_r = '0;
        for (int k = 0; k <= L; k++) dp[k] = 0;
    end
    always @(negedge clk) begin
        for (int k = L; k > 0; k--) dp[k] = dp[k-1];
        dp[0] = radius(calc_x, calc_y);
        calc_r = OW'(dp[L]);
    end

    // Reference model: pointer, last issued operands, queue of issued results with issue cycle.
    typedef struct {
        int t;
        int ch;
        int r;
    } item_t;

    item_t       q[$];
    int          m_p   = 0;
    logic [7:0]  m_cx  = '0;
    logic [7:0]  m_cy  = '0;
    logic        m_rv  = 1'b0;
    int          m_rch = 0;
    int          m_rr  = 0;
    int          tcyc  = 0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                int           g;
                int           idx;
                logic [N-1:0] exp_ready;
                logic         exp_busy;
                item_t        it;
                tcyc++;
                g = -1;
                for (int i = 0; i < N; i++) begin
                    idx = (m_p + i) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                exp_ready = '0;
                if (!reset && g >= 0) exp_ready[g] = 1'b1;
                exp_busy = 1'b0;
                foreach (q[i]) begin
                    if (tcyc >= q[i].t + 1 && tcyc <= q[i].t + 1 + L) exp_busy = 1'b1;
                end
                check("req_ready", 32'(req_ready), 32'(exp_ready));
                check("calc_x", 32'(calc_x), 32'(m_cx));
                check("calc_y", 32'(calc_y), 32'(m_cy));
                check("res_valid", 32'(res_valid), 32'(m_rv));
                check("res_ch", 32'(res_ch), 32'(m_rch));
                check("res_r", 32'(res_r), 32'(m_rr));
                check("busy", 32'(busy), 32'(exp_busy));

                if (reset) begin
                    m_p   = 0;
                    m_cx  = '0;
                    m_cy  = '0;
                    m_rv  = 1'b0;
                    m_rch = 0;
                    m_rr  = 0;
                    q.delete();
                end else begin
                    if (g >= 0) begin
                        it.t  = tcyc;
                        it.ch = g;
                        it.r  = radius(req_x[g*IW +: IW], req_y[g*IW +: IW]);
                        q.push_back(it);
                        m_cx = req_x[g*IW +: IW];
                        m_cy = req_y[g*IW +: IW];
                        m_p  = (g + 1) % N;
                    end
                    m_rv = 1'b0;
                    if (q.size() > 0 && q[0].t + L + 2 == tcyc + 1) begin
                        m_rv  = 1'b1;
                        m_rch = q[0].ch;
                        m_rr  = q[0].r;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        next_cycle();
        reset     = 1'b1;
        req_valid = '0;
        next_cycle();
        reset     = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] x, input logic [7:0] y);
        req_x[ch*IW +: IW] = x;
        req_y[ch*IW +: IW] = y;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_calc_x", 32'(calc_x), 32'd0);

        // Single request ch2 (3,4) -> radius 5 five cycles later.
        next_cycle();
        set_ch(2, 8'd3, 8'd4);
        req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) next_cycle();
            @(negedge clk);
            check("single_busy", 32'(busy), 32'd1);
        end
        next_cycle();
        @(negedge clk);
        check("single_res_valid", 32'(res_valid), 32'd1);
        check("single_res_ch", 32'(res_ch), 32'd2);
        check("single_res_r", 32'(res_r), 32'd5);

        // All channels requesting: strict rotation.
        reset_dut();
        for (int i = 0; i < N; i++) set_ch(i, 8'(i + 1), 8'd0);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("rotate_ready", 32'(req_ready), 32'(1 << (k % N)));
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("rotate_res_ch", 32'(res_ch), 32'd3);
        check("rotate_res_r", 32'(res_r), 32'd4);
        next_cycle();
        @(negedge clk);
        check("rotate_res_ch2", 32'(res_ch), 32'd0);
        check("rotate_res_r2", 32'(res_r), 32'd1);

        // Pointer skip over idle channels.
        reset_dut();
        req_valid = 4'b0001;
        @(negedge clk);
        check("skip_ready0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        check("skip_ready3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = 4'b0011;
        @(negedge clk);
        check("skip_wrap", 32'(req_ready), 32'b0001);

        // ch0 streaming, ch1 cuts in once.
        reset_dut();
        req_valid = 4'b0001;
        @(negedge clk);
        check("fair_c0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = 4'b0011;
        @(negedge clk);
        check("fair_c1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = 4'b0001;
        @(negedge clk);
        check("fair_c2", 32'(req_ready), 32'b0001);
        repeat (3) next_cycle();

        // Reset with three tags in flight discards them all.
        reset_dut();
        req_valid = 4'hF;
        next_cycle();
        next_cycle();
        next_cycle();
        req_valid = '0;
        next_cycle();
        reset     = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        check("rst_gate_ready", 32'(req_ready), 32'd0);
        next_cycle();
        reset     = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            check("flush_res_valid", 32'(res_valid), 32'd0);
            check("flush_busy", 32'(busy), 32'd0);
        end
        next_cycle();
        req_valid = 4'b0110;
        @(negedge clk);
        check("post_rst_grant", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = '0;

        // Negative and most-negative operands.
        reset_dut();
        set_ch(1, 8'hFA, 8'hF8);
        req_valid = 4'b0010;
        @(negedge clk);
        check("neg_ready", 32'(req_ready), 32'b0010);
        next_cycle();
        set_ch(3, 8'h80, 8'h80);
        req_valid = 4'b1000;
        @(negedge clk);
        check("neg_calc_x", 32'(calc_x), 32'hFA);
        check("neg_calc_y", 32'(calc_y), 32'hF8);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("minneg_calc_x", 32'(calc_x), 32'h80);
        repeat (3) next_cycle();
        @(negedge clk);
        check("neg_res_ch", 32'(res_ch), 32'd1);
        check("neg_res_r", 32'(res_r), 32'd10);
        next_cycle();
        @(negedge clk);
        check("minneg_res_r", 32'(res_r), 32'd181);

        // Randomised traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            next_cycle();
            reset     = ($urandom_range(0, 47) == 0);
            req_valid = N'($urandom);
            if ($urandom_range(0, 3) == 0) req_valid = '0;
            req_x = $urandom;
            req_y = $urandom;
        end
        next_cycle();
        reset     = 1'b0;
        req_valid = '0;
        repeat (10) next_cycle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
